// File: rtl/multi_chan_sender_pkg.sv
// rtl/multi_chan_sender_pkg.sv - shared types and constants for the multi-channel sender
//
// Contents:
//   state_t    - sender FSM states (IDLE, SEND, GAP, DONE)
//   MODE_*     - gap mode encodings on the 2-bit mode input
//   LFSR_TAPS  - Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
package multi_chan_sender_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_FIXED   = 2'd0;
    localparam logic [1:0] MODE_RANDOM  = 2'd1;
    localparam logic [1:0] MODE_B2B     = 2'd2;
    localparam logic [1:0] MODE_B2B_ALT = 2'd3;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/msend_lfsr.sv
// rtl/msend_lfsr.sv - free-running 16-bit Galois LFSR supplying one random bit per cycle
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, loads SEED
//   rnd   - bit 0 of the current LFSR state
module msend_lfsr
    import multi_chan_sender_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    output logic rnd
);

    logic [15:0] lfsr_q;

    // Right-shifting Galois form: the bit shifted out folds back through the tap mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign rnd = lfsr_q[0];

endmodule

// File: rtl/multi_chan_sender.sv
// rtl/multi_chan_sender.sv - round-robin multi-channel sequence generator with configurable idle gaps
//
// Ports:
//   clk, rst_n         - clock (rising edge), asynchronous active-low reset
//   run                - level enable; dropping it stops after the pending transfer
//   mode               - 0 fixed gap, 1 random gap, 2/3 back-to-back
//   gap_from, gap_to   - gap bounds in idle cycles, sampled at each accept
//   limit              - transfers per run, 0 = unlimited
//   ready              - sink handshake
//   valid, data, chan  - current transfer: sequence value of channel chan
//   busy, done         - FSM not idle / FSM in DONE
//   xfer_cnt           - accepts since start, saturating
module multi_chan_sender
    import multi_chan_sender_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int          CHANNELS  = 2,
    parameter int          GAP_W     = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic [GAP_W-1:0] gap_from,
    input  logic [GAP_W-1:0] gap_to,
    input  logic [15:0]      limit,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CW-1:0]    chan,
    output logic             busy,
    output logic             done,
    output logic [15:0]      xfer_cnt
);

    state_t           state_q, state_d;
    logic [CW-1:0]    chan_q;
    logic [WIDTH-1:0] seq_q [CHANNELS];
    logic [15:0]      xfer_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [GAP_W-1:0] from_q, to_q;
    logic [1:0]       mode_q;
    logic             lfsr_bit;
    logic             accept, last_xfer, stop_now, stop_gap;

    msend_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .rnd   (lfsr_bit)
    );

    // Gap stop rule for gap index k. With gap_to < gap_from the random clause
    // is always true once k >= gap_from, so mode 1 collapses to mode 0.
    function automatic logic gap_stop(input logic [1:0] m, input logic [GAP_W:0] k,
                                      input logic [GAP_W-1:0] lo, input logic [GAP_W-1:0] hi,
                                      input logic rnd);
        logic r;
        r = 1'b1;
        case (m)
            MODE_FIXED:             r = (k == {1'b0, lo});
            MODE_RANDOM:            r = (k >= {1'b0, lo}) && ((k >= {1'b0, hi}) || rnd);
            MODE_B2B, MODE_B2B_ALT: r = 1'b1;
            default:                r = 1'b1;
        endcase
        return r;
    endfunction

    assign accept    = (state_q == ST_SEND) && ready;
    assign last_xfer = (limit != 16'd0) && (({1'b0, xfer_q} + 17'd1) == {1'b0, limit});
    // At the accept itself k = 0; gap_cnt_q counts GAP cycles already finished,
    // so the GAP cycle being evaluated has k = gap_cnt_q + 1.
    assign stop_now  = gap_stop(mode, '0, gap_from, gap_to, lfsr_bit);
    assign stop_gap  = gap_stop(mode_q, {1'b0, gap_cnt_q} + {{GAP_W{1'b0}}, 1'b1},
                                from_q, to_q, lfsr_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_SEND;
            ST_SEND: begin
                if (accept) begin
                    if (last_xfer)     state_d = ST_DONE;
                    else if (!run)     state_d = ST_IDLE;
                    else if (stop_now) state_d = ST_SEND;
                    else               state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!run)          state_d = ST_IDLE;
                else if (stop_gap) state_d = ST_SEND;
            end
            ST_DONE: if (!run) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q    <= '0;
            xfer_q    <= '0;
            gap_cnt_q <= '0;
            from_q    <= '0;
            to_q      <= '0;
            mode_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) seq_q[i] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        chan_q <= '0;
                        xfer_q <= '0;
                        for (int i = 0; i < CHANNELS; i++) seq_q[i] <= '0;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (chan_q == CW'(i)) seq_q[i] <= seq_q[i] + 1'b1;
                        end
                        chan_q    <= (chan_q == CW'(CHANNELS - 1)) ? '0 : chan_q + 1'b1;
                        if (xfer_q != 16'hFFFF) xfer_q <= xfer_q + 16'd1;
                        gap_cnt_q <= '0;
                        from_q    <= gap_from;
                        to_q      <= gap_to;
                        mode_q    <= mode;
                    end
                end
                ST_GAP:  gap_cnt_q <= gap_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chan_q == CW'(i)) data = seq_q[i];
        end
    end

    assign valid    = (state_q == ST_SEND);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign chan     = chan_q;
    assign xfer_cnt = xfer_q;

endmodule

// File: doc/multi_chan_sender.md
MULTI_CHAN_SENDER -- requirements
Module: multi_chan_sender

Interface
REQ-001 Parameter WIDTH, default 4: data width; each channel's sequence counter wraps at 2^WIDTH.
REQ-002 Parameter CHANNELS, default 2: number of round-robin channels, legal range 1..16.
REQ-003 Parameter GAP_W, default 8: width of the gap configuration inputs and the internal gap counter.
REQ-004 Parameter LFSR_SEED, default 16'hACE1: nonzero reset value of the 16-bit LFSR.
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 run  in  1  level; 1 = generate transfers, 0 = stop after the pending transfer.
REQ-008 mode  in  2  0 = fixed gap, 1 = random gap, 2 = back-to-back, 3 = same as 2.
REQ-009 gap_from, gap_to  in  GAP_W each  gap bounds in idle cycles; sampled at each accept.
REQ-010 limit  in  16  transfers per run; 0 = unlimited.
REQ-011 ready  in  1  sink accepts data when valid and ready are both 1 (accept).
REQ-012 valid  out  1  data and chan are meaningful.
REQ-013 data  out  WIDTH  current sequence value of channel chan.
REQ-014 chan  out  max(1,$clog2(CHANNELS))  channel of the current transfer.
REQ-015 busy, done  out  1 each  busy = not IDLE; done = in DONE.
REQ-016 xfer_cnt  out  16  accepts since start, saturating at 16'hFFFF.

Function
REQ-017 FSM states: IDLE, SEND, GAP, DONE; valid = 1 exactly in SEND.
REQ-018 IDLE with run=1: clear all sequence counters, chan and xfer_cnt, then go to SEND next cycle.
REQ-019 SEND: data, chan stay stable until accept; valid never drops without an accept (run=0 included).
REQ-020 On accept: seq[chan] += 1 (mod 2^WIDTH); chan advances round-robin, CHANNELS-1 -> 0; xfer_cnt += 1.
REQ-021 After an accept, the gap length L is the number of cycles with valid=0 before the next transfer.
REQ-022 Gap counter k starts at 0 at each accept and increments once per GAP cycle.
REQ-023 Stop rule is evaluated at the accept (k=0) and then every GAP cycle; when it holds, the next state is SEND.
REQ-024 Mode 0 stop rule: k == gap_from, so L = gap_from.
REQ-025 Mode 1 stop rule: k >= gap_from and (k >= gap_to or lfsr[0]==1), so gap_from <= L <= max(gap_from,gap_to).
REQ-026 Mode 1 with gap_to < gap_from behaves as mode 0.
REQ-027 Modes 2 and 3: L = 0; valid stays high across consecutive accepts.
REQ-028 Accept with limit != 0 and xfer_cnt+1 == limit -> DONE; this takes priority over the gap decision.
REQ-029 Accept with run=0 -> IDLE.
REQ-030 GAP with run=0 -> IDLE immediately.
REQ-031 DONE holds done=1 and valid=0 until run=0, then goes to IDLE; xfer_cnt holds in DONE and IDLE.
REQ-032 LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1; advances every cycle regardless of state.

Reset
REQ-033 rst_n=0: state = IDLE; valid, busy, done, data, chan, xfer_cnt, gap counter and sequence counters = 0; LFSR = LFSR_SEED.
REQ-034 Reset during SEND or GAP aborts the transfer: valid falls asynchronously and nothing counts as accepted.

Structure
REQ-035 Package multi_chan_sender_pkg holds the state enum, the mode encodings and the LFSR tap constant.
REQ-036 Sub-module msend_lfsr (16-bit Galois LFSR with seed parameter) is the only child instance.

Verification
REQ-037 Mode 2, CHANNELS=2, ready=1, limit=6: (chan,data) = (0,0),(1,0),(0,1),(1,1),(0,2),(1,2) on consecutive cycles; then done=1, xfer_cnt=6.
REQ-038 Mode 0, gap_from=5, ready=1: exactly 5 valid=0 cycles between successive accepts, checked over 50 transfers.
REQ-039 Mode 1, gap_from=0, gap_to=10: every L in [0,10], at least 3 distinct L values in 50 transfers; a scoreboard checks per-channel data increments mod 16.
REQ-040 Ready low for 7 cycles with valid=1, then run=0 during the stall: valid, data, chan stable throughout; after the accept the FSM returns to IDLE.
REQ-041 WIDTH=4, one channel, 20 transfers: data wraps 15 -> 0 with no error.
REQ-042 rst_n pulsed low mid-GAP and mid-SEND: all outputs read 0 at once; a restart begins at data=0, chan=0.
